regfile_sb: RTL and testbench

REGFILE_SB -- requirements
Module: regfile_sb

---
 rtl/regfile_sb.sv | 117 +++++++++++
 tb/tb_regfile_sb.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// Register file with three registered read ports, a pending-producer scoreboard
// and a dedicated program-counter register that supports load, write and increment.
module regfile_sb #(
  parameter int                DATA_W   = 16,
  parameter int                ADDR_W   = 4,
  parameter int                PC_IDX   = 2**ADDR_W-1,
  parameter logic [DATA_W-1:0] PC_RESET = '0,
  parameter int                PC_STEP  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] sel0,
  input  logic [ADDR_W-1:0] sel1,
  input  logic [ADDR_W-1:0] insr,
  input  logic              write_en,
  input  logic [ADDR_W-1:0] write_address,
  input  logic [DATA_W-1:0] data_in,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  input  logic              pc_inc,
  input  logic              pc_load,
  input  logic [DATA_W-1:0] pc_in,
  output logic [DATA_W-1:0] out0,
  output logic [DATA_W-1:0] out1,
  output logic [DATA_W-1:0] outvalue,
  output logic              busy0,
  output logic              busy1,
  output logic              busyv,
  output logic [DATA_W-1:0] PC
);

  localparam int                DEPTH     = 2**ADDR_W;
  localparam int                NPORT     = 3;
  localparam logic [DATA_W-1:0] PC_STEP_V = DATA_W'(PC_STEP);

  logic [DATA_W-1:0] regs_reg  [DEPTH];
  logic [DATA_W-1:0] regs_next [DEPTH];
  logic [DEPTH-1:0]  pending_reg;
  logic [DEPTH-1:0]  pending_next;
  logic [DEPTH-1:0]  wr_sel;
  logic [DEPTH-1:0]  rsv_sel;
  logic [DATA_W-1:0] pc_next;

  logic [ADDR_W-1:0] rd_addr     [NPORT];
  logic [DATA_W-1:0] rd_data_reg [NPORT];
  logic [NPORT-1:0]  rd_busy_reg;

  // Per-register next state; a reservation overrides a same-cycle write clear.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_reg
      localparam logic [ADDR_W-1:0] IDX = ADDR_W'(gi);
      assign wr_sel[gi]       = write_en && (write_address == IDX);
      assign rsv_sel[gi]      = rsv_en && (rsv_addr == IDX);
      assign pending_next[gi] = rsv_sel[gi] | (pending_reg[gi] & ~wr_sel[gi]);
      if (gi == PC_IDX) begin : g_pc
        assign regs_next[gi] = pc_next;
      end else begin : g_gp
        assign regs_next[gi] = wr_sel[gi] ? data_in : regs_reg[gi];
      end
    end
  endgenerate

  // PC priority: load, then architectural write, then increment (wraps silently).
  always_comb begin
    pc_next = regs_reg[PC_IDX];
    if (pc_load) begin
      pc_next = pc_in;
    end else if (wr_sel[PC_IDX]) begin
      pc_next = data_in;
    end else if (pc_inc) begin
      pc_next = regs_reg[PC_IDX] + PC_STEP_V;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_reg <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        regs_reg[i] <= (i == PC_IDX) ? PC_RESET : '0;
      end
    end else begin
      pending_reg <= pending_next;
      for (int i = 0; i < DEPTH; i++) begin
        regs_reg[i] <= regs_next[i];
      end
    end
  end

  assign rd_addr[0] = sel0;
  assign rd_addr[1] = sel1;
  assign rd_addr[2] = insr;

  // Reads see the state being committed at this edge, giving write-first bypass.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_busy_reg <= '0;
      for (int p = 0; p < NPORT; p++) begin
        rd_data_reg[p] <= '0;
      end
    end else begin
      for (int p = 0; p < NPORT; p++) begin
        rd_data_reg[p] <= regs_next[rd_addr[p]];
        rd_busy_reg[p] <= pending_next[rd_addr[p]];
      end
    end
  end

  assign out0     = rd_data_reg[0];
  assign out1     = rd_data_reg[1];
  assign outvalue = rd_data_reg[2];
  assign busy0    = rd_busy_reg[0];
  assign busy1    = rd_busy_reg[1];
  assign busyv    = rd_busy_reg[2];
  assign PC       = regs_reg[PC_IDX];

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: two instances (default PC reset and PC_RESET=0x0100)
// checked every cycle against an array/scoreboard model plus literal expectations.
module tb_regfile_sb;

  localparam logic [15:0] PC_RESET_B = 16'h0100;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  sel0, sel1, insr, write_address, rsv_addr;
  logic        write_en, rsv_en, pc_inc, pc_load;
  logic [15:0] data_in, pc_in;

  logic [15:0] a_out0, a_out1, a_outvalue, a_pc;
  logic        a_busy0, a_busy1, a_busyv;
  logic [15:0] b_out0, b_out1, b_outvalue, b_pc;
  logic        b_busy0, b_busy1, b_busyv;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  regfile_sb dut_a (
    .clk(clk), .rst(rst), .sel0(sel0), .sel1(sel1), .insr(insr),
    .write_en(write_en), .write_address(write_address), .data_in(data_in),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .pc_inc(pc_inc), .pc_load(pc_load),
    .pc_in(pc_in), .out0(a_out0), .out1(a_out1), .outvalue(a_outvalue),
    .busy0(a_busy0), .busy1(a_busy1), .busyv(a_busyv), .PC(a_pc)
  );

  regfile_sb #(.PC_RESET(PC_RESET_B)) dut_b (
    .clk(clk), .rst(rst), .sel0(sel0), .sel1(sel1), .insr(insr),
    .write_en(write_en), .write_address(write_address), .data_in(data_in),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .pc_inc(pc_inc), .pc_load(pc_load),
    .pc_in(pc_in), .out0(b_out0), .out1(b_out1), .outvalue(b_outvalue),
    .busy0(b_busy0), .busy1(b_busy1), .busyv(b_busyv), .PC(b_pc)
  );

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Model: register contents per instance, shared pending set, expected outputs.
  logic [15:0] m_regs [2][16];
  logic [15:0] m_pend;
  logic [15:0] m_out  [2][3];
  logic [2:0]  m_busy;
  logic [15:0] m_pc_new;
  logic [3:0]  m_addr [3];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        for (int i = 0; i < 16; i++) m_regs[k][i] = 16'h0;
        for (int p = 0; p < 3; p++) m_out[k][p] = 16'h0;
      end
      m_regs[1][15] = PC_RESET_B;
      m_pend = 16'h0;
      m_busy = 3'b0;
    end else begin
      m_addr[0] = sel0;
      m_addr[1] = sel1;
      m_addr[2] = insr;
      for (int k = 0; k < 2; k++) begin
        if (pc_load) m_pc_new = pc_in;
        else if (write_en && write_address == 4'd15) m_pc_new = data_in;
        else if (pc_inc) m_pc_new = m_regs[k][15] + 16'd1;
        else m_pc_new = m_regs[k][15];
        if (write_en && write_address != 4'd15) m_regs[k][write_address] = data_in;
        m_regs[k][15] = m_pc_new;
        for (int p = 0; p < 3; p++) m_out[k][p] = m_regs[k][m_addr[p]];
      end
      if (write_en) m_pend[write_address] = 1'b0;
      if (rsv_en) m_pend[rsv_addr] = 1'b1;
      for (int p = 0; p < 3; p++) m_busy[p] = m_pend[m_addr[p]];
    end
  end

  always @(negedge clk) begin
    chk("cmp_out0_a", a_out0, m_out[0][0]);
    chk("cmp_out1_a", a_out1, m_out[0][1]);
    chk("cmp_outvalue_a", a_outvalue, m_out[0][2]);
    chk("cmp_pc_a", a_pc, m_regs[0][15]);
    chk("cmp_busy_a", {13'b0, a_busyv, a_busy1, a_busy0}, {13'b0, m_busy});
    chk("cmp_out0_b", b_out0, m_out[1][0]);
    chk("cmp_out1_b", b_out1, m_out[1][1]);
    chk("cmp_outvalue_b", b_outvalue, m_out[1][2]);
    chk("cmp_pc_b", b_pc, m_regs[1][15]);
    chk("cmp_busy_b", {13'b0, b_busyv, b_busy1, b_busy0}, {13'b0, m_busy});
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    write_en = 1'b0; rsv_en = 1'b0; pc_inc = 1'b0; pc_load = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    sel0 = 4'd0; sel1 = 4'd0; insr = 4'd15;
    write_address = 4'd0; rsv_addr = 4'd0; data_in = 16'h0; pc_in = 16'h0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out0_a", a_out0, 16'h0);
    chk("rst_pc_a", a_pc, 16'h0);
    chk("rst_pc_b", b_pc, 16'h0100);
    chk("rst_busyv_a", {15'b0, a_busyv}, 16'h0);
    #3 rst = 1'b0;
    step();
    chk("pcreset_outvalue_b", b_outvalue, 16'h0100);
    chk("pcreset_outvalue_a", a_outvalue, 16'h0);

    // Write-first bypass, then write_en=0 must not modify
    write_en = 1'b1; write_address = 4'd1; data_in = 16'd2; sel0 = 4'd1;
    step();
    chk("bypass_out0", a_out0, 16'd2);
    write_en = 1'b0; data_in = 16'd4;
    step();
    chk("nowrite_out0", a_out0, 16'd2);

    for (int i = 0; i < 15; i++) begin
      write_en = 1'b1; write_address = 4'(i); data_in = 16'(i); sel0 = 4'(i);
      step();
    end
    write_en = 1'b0;
    for (int i = 0; i < 15; i++) begin
      sel0 = 4'(i);
      step();
      chk("fwd_read_out0", a_out0, 16'(i));
    end
    for (int i = 0; i < 15; i++) begin
      write_en = 1'b1; write_address = 4'(i); data_in = 16'(15 - i);
      step();
    end
    write_en = 1'b0;
    for (int i = 0; i < 15; i++) begin
      sel0 = 4'(i);
      step();
      chk("rev_read_out0", a_out0, 16'(15 - i));
    end

    // PC load/wrap/priority
    pc_load = 1'b1; pc_in = 16'hFFFF;
    step();
    chk("pc_load", a_pc, 16'hFFFF);
    pc_load = 1'b0; pc_inc = 1'b1;
    step();
    chk("pc_wrap_a", a_pc, 16'h0000);
    chk("pc_wrap_b", b_pc, 16'h0000);
    pc_load = 1'b1; pc_in = 16'h1234; write_en = 1'b1; write_address = 4'd15;
    data_in = 16'h5555; insr = 4'd15;
    step();
    chk("pc_prio_load", a_pc, 16'h1234);
    chk("pc_prio_read", a_outvalue, 16'h1234);
    pc_load = 1'b0;
    step();
    chk("pc_prio_write", a_pc, 16'h5555);
    write_en = 1'b0;
    step();
    chk("pc_inc", a_pc, 16'h5556);
    idle();

    // Scoreboard
    rsv_en = 1'b1; rsv_addr = 4'd3; sel0 = 4'd3;
    step();
    chk("rsv_busy0", {15'b0, a_busy0}, 16'h1);
    chk("rsv_stale_out0", a_out0, 16'd12);
    rsv_en = 1'b0;
    step();
    chk("rsv_hold_busy0", {15'b0, a_busy0}, 16'h1);
    write_en = 1'b1; write_address = 4'd3; data_in = 16'd7;
    step();
    chk("wr_clear_busy0", {15'b0, a_busy0}, 16'h0);
    chk("wr_clear_out0", a_out0, 16'd7);
    rsv_en = 1'b1; rsv_addr = 4'd3; data_in = 16'd9;
    step();
    chk("rsv_wins_out0", a_out0, 16'd9);
    chk("rsv_wins_busy0", {15'b0, a_busy0}, 16'h1);
    rsv_addr = 4'd4; write_address = 4'd5; data_in = 16'h0055; sel0 = 4'd4; sel1 = 4'd5;
    step();
    chk("split_busy0", {15'b0, a_busy0}, 16'h1);
    chk("split_out0", a_out0, 16'd11);
    chk("split_busy1", {15'b0, a_busy1}, 16'h0);
    chk("split_out1", a_out1, 16'h0055);
    idle();
    sel0 = 4'd3; sel1 = 4'd3; insr = 4'd3;
    step();
    chk("same_addr_out1", a_out1, 16'd9);
    chk("same_addr_outvalue", a_outvalue, 16'd9);
    chk("same_addr_busyv", {15'b0, a_busyv}, 16'h1);

    // Async reset mid-cycle; operations under reset are discarded
    write_en = 1'b1; write_address = 4'd6; data_in = 16'h0066; sel0 = 4'd6;
    step();
    chk("pre_rst_out0", a_out0, 16'h0066);
    write_address = 4'd2; data_in = 16'hAAAA; rsv_en = 1'b1; rsv_addr = 4'd2; pc_inc = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("async_rst_out0", a_out0, 16'h0);
    chk("async_rst_busy", {13'b0, a_busyv, a_busy1, a_busy0}, 16'h0);
    chk("async_rst_pc_a", a_pc, 16'h0);
    chk("async_rst_pc_b", b_pc, 16'h0100);
    @(posedge clk);
    #1;
    idle();
    #2 rst = 1'b0;
    sel0 = 4'd2; sel1 = 4'd6; insr = 4'd15;
    step();
    chk("post_rst_out0", a_out0, 16'h0);
    chk("post_rst_busy0", {15'b0, a_busy0}, 16'h0);
    chk("post_rst_out1", a_out1, 16'h0);
    chk("post_rst_outvalue_b", b_outvalue, 16'h0100);

    // Mixed directed traffic, checked each cycle by the compare process
    for (int i = 0; i < 16; i++) begin
      write_en = (i % 2) == 1; write_address = 4'(i * 7); data_in = 16'(i * 16'h1111);
      rsv_en = ((i / 2) % 2) == 1; rsv_addr = 4'(i * 3);
      pc_inc = ((i / 4) % 2) == 1; pc_load = (i == 9); pc_in = 16'hBEEF;
      sel0 = 4'(i); sel1 = 4'(i * 5); insr = 4'd15;
      step();
    end
    idle();
    step();
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
